// File: rtl/jk_bank_sched.sv
// jk_bank_sched: two-requester command scheduler driving a bank of WIDTH JK
// flip-flops. Each accepted command walks IDLE -> APPLY -> DONE. During APPLY
// the J/K drive is presented, and q takes the JK result at the edge that ends
// APPLY. DONE pulses done/done_id, and done_cnt advances at the edge that ends
// DONE.
//
// Optional build macro: JK_BANK_SCHED_PRIO_EN
//   When it is defined, requester 0 always wins a conflict (fixed priority).
//   When it is undefined, conflicts alternate between the requesters (round-robin).
//
// Handshake: a command is accepted on a rising edge where reqN_valid and
// reqN_ready are both high. reqN_ready is high only in IDLE, only when rst is
// low, and only for the granted requester, so at most one ready is high at a
// time. Changes on valid outside IDLE are ignored. The requester must hold
// op and mask stable while valid is high and ready is low.
module jk_bank_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [1:0]       req0_op,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req0_mask,
    input  logic [WIDTH-1:0] req1_mask,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic             done,
    output logic             done_id,
    output logic [7:0]       done_cnt,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             id_q, id_d;
    logic             last_q, last_d;   // requester granted most recently
    logic [WIDTH-1:0] q_q, q_d;
    logic [7:0]       cnt_q, cnt_d;

    logic grant_valid;
    logic grant_id;
    logic hs;

    // Arbitration: choose the requester that is offered ready this cycle.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
`ifdef JK_BANK_SCHED_PRIO_EN
        grant_id = ~req0_valid;
`else
        if (req0_valid && req1_valid) begin
            grant_id = ~last_q;
        end else begin
            grant_id = ~req0_valid;
        end
`endif
        hs = (state_q == S_IDLE) && !rst && grant_valid;
    end

    // State register. rst overrides everything, including an in-flight command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: APPLY and DONE each last exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (hs) state_d = S_APPLY;
            S_APPLY: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: readies, J/K drive and the done pulse.
    always_comb begin
        req0_ready = hs && !grant_id;
        req1_ready = hs && grant_id;
        j          = '0;
        k          = '0;
        if (state_q == S_APPLY) begin
            j = mask_q & {WIDTH{op_q[1]}};
            k = mask_q & {WIDTH{op_q[0]}};
        end
        done      = (state_q == S_DONE);
        done_id   = id_q;
        q         = q_q;
        done_cnt  = cnt_q;
        state_dbg = state_q;
    end

    // Datapath next values: latch the command, apply the JK rule, and count completions.
    always_comb begin
        op_d   = op_q;
        mask_d = mask_q;
        id_d   = id_q;
        last_d = last_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        if (hs) begin
            id_d   = grant_id;
            last_d = grant_id;
            op_d   = grant_id ? req1_op : req0_op;
            mask_d = grant_id ? req1_mask : req0_mask;
        end
        if (state_q == S_APPLY) begin
            q_d = (j & ~q_q) | (~k & q_q);
        end
        if (state_q == S_DONE) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Datapath registers. last_q resets to 1 so that requester 0 wins the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= 2'b00;
            mask_q <= '0;
            id_q   <= 1'b0;
            last_q <= 1'b1;
            q_q    <= '0;
            cnt_q  <= 8'd0;
        end else begin
            op_q   <= op_d;
            mask_q <= mask_d;
            id_q   <= id_d;
            last_q <= last_d;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_jk_bank_sched.sv
// Testbench for jk_bank_sched (WIDTH=4). A bench model predicts q, done_id and
// done_cnt for every accepted command. Predictions are queued at handshake
// time, then popped and compared when done pulses.
module tb_jk_bank_sched;

  localparam int W = 4;
  localparam logic [1:0] OP_HOLD = 2'b00, OP_CLEAR = 2'b01, OP_SET = 2'b10, OP_TOGGLE = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_op = 2'b00, req1_op = 2'b00;
  logic [W-1:0] req0_mask = '0, req1_mask = '0;
  logic [W-1:0] j, k, q;
  logic         done, done_id;
  logic [7:0]   done_cnt;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // expected entry layout: {id, q_after, done_cnt_seen_during_done}
  logic [12:0]  exp_q[$];
  logic [W-1:0] model_q   = '0;
  logic [7:0]   model_cnt = 8'd0;

  jk_bank_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_mask(req0_mask), .req1_mask(req1_mask),
    .j(j), .k(k), .q(q),
    .done(done), .done_id(done_id), .done_cnt(done_cnt),
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_req(input int r, input logic v, input logic [1:0] op, input logic [W-1:0] m);
    if (r == 0) begin
      req0_valid = v; req0_op = op; req0_mask = m;
    end else begin
      req1_valid = v; req1_op = op; req1_mask = m;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_q   = '0;
    model_cnt = 8'd0;
    exp_q.delete();
  endtask

  // Independent JK-bank reference: predict the next q and push the expected completion.
  task automatic push_expected(input int r, input logic [1:0] op, input logic [W-1:0] m);
    logic [W-1:0] nq;
    case (op)
      OP_SET:    nq = model_q | m;
      OP_CLEAR:  nq = model_q & ~m;
      OP_TOGGLE: nq = model_q ^ m;
      default:   nq = model_q;
    endcase
    exp_q.push_back({(r != 0), nq, model_cnt});
    model_q   = nq;
    model_cnt = model_cnt + 8'd1;
  endtask

  // Expected J/K for one op: j = SET or TOGGLE bits, k = CLEAR or TOGGLE bits.
  function automatic logic [2*W-1:0] exp_jk(input logic [1:0] op, input logic [W-1:0] m);
    case (op)
      OP_SET:    return {m, {W{1'b0}}};
      OP_CLEAR:  return {{W{1'b0}}, m};
      OP_TOGGLE: return {m, m};
      default:   return '0;
    endcase
  endfunction

  // Call at a negedge. Returns at the negedge of the APPLY cycle after checking J/K.
  task automatic do_cmd(input int r, input logic [1:0] op, input logic [W-1:0] m);
    int n = 0;
    set_req(r, 1'b1, op, m);
    #1;
    while (!(r != 0 ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      check("ready_timeout", 32'd0, 32'd1);
      set_req(r, 1'b0, 2'b00, '0);
      return;
    end
    push_expected(r, op, m);
    @(posedge clk); #1;
    set_req(r, 1'b0, 2'b00, '0);
    @(negedge clk);
    check("apply_jk", {j, k}, exp_jk(op, m));
    check("apply_no_ready", {req0_ready, req1_ready}, 2'b00);
  endtask

  // scoreboard: compare each done pulse against the oldest prediction
  always @(negedge clk) begin
    logic [12:0] e;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_id", done_id, e[12]);
        check("done_q", q, e[11:8]);
        check("done_cnt_in_done", done_cnt, e[7:0]);
        check("done_jk_zero", {j, k}, '0);
      end
    end
  end

  int got_g, exp_g, n_w;

  initial begin
    // reset state, with both requesters asserting valid during reset
    rst = 1'b1;
    set_req(0, 1'b1, OP_SET, 4'hF);
    set_req(1, 1'b1, OP_SET, 4'hF);
    @(negedge clk); @(negedge clk);
    check("rst_readies", {req0_ready, req1_ready}, 2'b00);
    check("rst_q", q, 4'h0);
    check("rst_jk", {j, k}, 8'h00);
    check("rst_done", {done, done_id}, 2'b00);
    check("rst_cnt", done_cnt, 8'd0);
    set_req(0, 1'b0, 2'b00, '0);
    set_req(1, 1'b0, 2'b00, '0);
    do_reset();

    // req0 SET 1111, then req1 TOGGLE 0101 and CLEAR 1000
    do_cmd(0, OP_SET, 4'hF);
    repeat (2) @(negedge clk);
    check("set_q", q, 4'hF);
    check("set_cnt", done_cnt, 8'd1);
    do_cmd(1, OP_TOGGLE, 4'h5);
    repeat (2) @(negedge clk);
    check("toggle_q", q, 4'hA);
    do_cmd(1, OP_CLEAR, 4'h8);
    repeat (2) @(negedge clk);
    check("clear_q", q, 4'h2);
    check("clear_cnt", done_cnt, 8'd3);

    // valid raised during DONE: no ready until IDLE, then ready the next cycle
    do_cmd(0, OP_SET, 4'h1);
    @(negedge clk);
    check("in_done", done, 1'b1);
    set_req(1, 1'b1, OP_TOGGLE, 4'h3);
    #1;
    check("done_no_ready", {req0_ready, req1_ready}, 2'b00);
    @(negedge clk); #1;
    check("idle_ready_after_done", {done, req1_ready}, 2'b01);
    push_expected(1, OP_TOGGLE, 4'h3);
    @(posedge clk); #1;
    set_req(1, 1'b0, 2'b00, '0);
    repeat (3) @(negedge clk);
    check("late_q", q, 4'h0);

    // both requesters hold valid: grant order
    do_reset();
    set_req(0, 1'b1, OP_TOGGLE, 4'h3);
    set_req(1, 1'b1, OP_SET, 4'hC);
    for (int i = 0; i < 4; i++) begin
      n_w = 0;
      #1;
      while (!(req0_ready || req1_ready) && n_w < 20) begin
        @(negedge clk); #1; n_w++;
      end
      if (n_w >= 20) begin
        check("grant_timeout", 32'd0, 32'd1);
        break;
      end
      check("grant_onehot", {req0_ready, req1_ready} == 2'b11, 1'b0);
      got_g = req1_ready ? 1 : 0;
`ifdef JK_BANK_SCHED_PRIO_EN
      exp_g = 0;
`else
      exp_g = i % 2;
`endif
      check("grant_order", got_g, exp_g);
      if (exp_g == 0) push_expected(0, OP_TOGGLE, 4'h3);
      else            push_expected(1, OP_SET, 4'hC);
      @(posedge clk);
      @(negedge clk);
    end
    set_req(0, 1'b0, 2'b00, '0);
    set_req(1, 1'b0, 2'b00, '0);
    repeat (3) @(negedge clk);
    check("grant_final_q", q, model_q);

    // reset during APPLY aborts the command
    do_reset();
    set_req(0, 1'b1, OP_SET, 4'hF);
    #1;
    check("abort_ready", req0_ready, 1'b1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 2'b00, '0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_apply_jk", {j, k}, 8'hF0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_q", q, 4'h0);
    check("abort_cnt", done_cnt, 8'd0);

    // done_cnt wrap: one SET, then 255 commands that leave q unchanged
    do_cmd(0, OP_SET, 4'h6);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 255; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_cmd($urandom_range(0, 1), OP_HOLD, 4'($urandom_range(0, 15)));
      else
        do_cmd($urandom_range(0, 1), 2'($urandom_range(0, 3)), 4'h0);
      repeat (2) @(negedge clk);
    end
    check("wrap_cnt", done_cnt, 8'd0);
    check("wrap_q", q, 4'h6);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
